hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_pkg.sv | 30 +++
 rtl/hazard_stall_unit_tag_pipe.sv | 29 ++
 rtl/hazard_stall_unit.sv | 128 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard/stall unit: FSM state encoding, per-stage
// destination tag record, counter widths and the load-use match helper.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_tag_t;

    localparam int unsigned STALL_COUNT_W = 16;
    localparam int unsigned BUBBLE_CNT_W  = 2;

    // A load in ID/EX feeds a source the decode instruction actually reads; x0 never hazards.
    function automatic logic load_use_hit(input stage_tag_t t,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2,
                                          input logic       uses_rs1,
                                          input logic       uses_rs2);
        return t.mem_read && (t.rd != 5'd0) &&
               (((t.rd == rs1) && uses_rs1) || ((t.rd == rs2) && uses_rs2));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_tag_pipe.sv
// Three-stage destination tag shift register (ID/EX -> EX/MEM -> MEM/WB).
// en=0 freezes every stage; clr injects an all-zero tag into ID/EX.
module tag_pipe
    import hazard_stall_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  stage_tag_t in_tag,
    output stage_tag_t id_ex,
    output stage_tag_t ex_mem,
    output stage_tag_t mem_wb
);

    // Shift tags one stage per enabled cycle; async reset empties the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (en) begin
            id_ex  <= clr ? '0 : in_tag;
            ex_mem <= id_ex;
            mem_wb <= ex_mem;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use stall FSM, branch flush and
// memory hold, plus the registered destination tags per stage.
// Optional macro HAZARD_STALL_COUNT_EN enables the saturating bubble counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned LOAD_USE_STALLS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID__Rs1,
    input  logic [4:0]  IF_ID__Rs2,
    input  logic        IF_ID__Uses_Rs1,
    input  logic        IF_ID__Uses_Rs2,
    input  logic [4:0]  ID_Rd,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        Branch_Taken,
    input  logic        Hold,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        Flush,
    output logic [4:0]  ID_EX__Rd,
    output logic [4:0]  EX_MEM__Rd,
    output logic [4:0]  MEM_WB__Rd,
    output logic        ID_EX__MemRead,
    output logic        EX_MEM__RegWrite,
    output logic        MEM_WB__RegWrite,
    output logic [15:0] Stall_Count
);

    hz_state_t                 state, state_n;
    logic [BUBBLE_CNT_W-1:0]   cnt, cnt_n;
    stage_tag_t                t_id_ex, t_ex_mem, t_mem_wb;
    logic                      load_use;

    tag_pipe u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .en     (!Hold),
        .clr    (ID_EX_Bubble | Flush),
        .in_tag ('{rd: ID_Rd, reg_write: ID_RegWrite, mem_read: ID_MemRead}),
        .id_ex  (t_id_ex),
        .ex_mem (t_ex_mem),
        .mem_wb (t_mem_wb)
    );

    assign ID_EX__Rd        = t_id_ex.rd;
    assign EX_MEM__Rd       = t_ex_mem.rd;
    assign MEM_WB__Rd       = t_mem_wb.rd;
    assign ID_EX__MemRead   = t_id_ex.mem_read;
    assign EX_MEM__RegWrite = t_ex_mem.reg_write;
    assign MEM_WB__RegWrite = t_mem_wb.reg_write;

    assign load_use = load_use_hit(t_id_ex, IF_ID__Rs1, IF_ID__Rs2,
                                   IF_ID__Uses_Rs1, IF_ID__Uses_Rs2);

    // FSM state and remaining-bubble counter; Hold keeps both frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Priority Hold > Branch_Taken > stall/load-use > normal flow.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        Flush        = 1'b0;
        state_n      = state;
        cnt_n        = cnt;
        if (Hold) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (Branch_Taken) begin
            Flush   = 1'b1;
            state_n = FLUSH;
            cnt_n   = '0;
        end else begin
            unique case (state)
                STALL: begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    cnt_n        = cnt - 1'b1;
                    if (cnt <= 1) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = RUN;
                    if (load_use) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        cnt_n        = BUBBLE_CNT_W'(LOAD_USE_STALLS - 1);
                        if (LOAD_USE_STALLS > 1) state_n = STALL;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [STALL_COUNT_W-1:0] stall_count_q;

    // Saturating count of bubble cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (ID_EX_Bubble && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign Stall_Count = stall_count_q;
`else
    assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: two instances (1 and 3 bubbles per load-use) share
// stimulus and are compared every cycle against a cycle-level reference model.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, id_rd;
    logic        u1, u2, id_rw, id_mr, br, hold;

    logic        pc_a, ifid_a, bub_a, fl_a, idexmr_a, exmemrw_a, memwbrw_a;
    logic [4:0]  idexrd_a, exmemrd_a, memwbrd_a;
    logic [15:0] sc_a;
    logic        pc_b, ifid_b, bub_b, fl_b, idexmr_b, exmemrw_b, memwbrw_b;
    logic [4:0]  idexrd_b, exmemrd_b, memwbrd_b;
    logic [15:0] sc_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_USE_STALLS(1)) u_a (
        .clk(clk), .reset(reset),
        .IF_ID__Rs1(rs1), .IF_ID__Rs2(rs2),
        .IF_ID__Uses_Rs1(u1), .IF_ID__Uses_Rs2(u2),
        .ID_Rd(id_rd), .ID_RegWrite(id_rw), .ID_MemRead(id_mr),
        .Branch_Taken(br), .Hold(hold),
        .PC_Write(pc_a), .IF_ID_Write(ifid_a), .ID_EX_Bubble(bub_a), .Flush(fl_a),
        .ID_EX__Rd(idexrd_a), .EX_MEM__Rd(exmemrd_a), .MEM_WB__Rd(memwbrd_a),
        .ID_EX__MemRead(idexmr_a), .EX_MEM__RegWrite(exmemrw_a),
        .MEM_WB__RegWrite(memwbrw_a), .Stall_Count(sc_a)
    );

    hazard_stall_unit #(.LOAD_USE_STALLS(3)) u_b (
        .clk(clk), .reset(reset),
        .IF_ID__Rs1(rs1), .IF_ID__Rs2(rs2),
        .IF_ID__Uses_Rs1(u1), .IF_ID__Uses_Rs2(u2),
        .ID_Rd(id_rd), .ID_RegWrite(id_rw), .ID_MemRead(id_mr),
        .Branch_Taken(br), .Hold(hold),
        .PC_Write(pc_b), .IF_ID_Write(ifid_b), .ID_EX_Bubble(bub_b), .Flush(fl_b),
        .ID_EX__Rd(idexrd_b), .EX_MEM__Rd(exmemrd_b), .MEM_WB__Rd(memwbrd_b),
        .ID_EX__MemRead(idexmr_b), .EX_MEM__RegWrite(exmemrw_b),
        .MEM_WB__RegWrite(memwbrw_b), .Stall_Count(sc_b)
    );

    logic [3:0]  ctl_a, ctl_b;
    logic [17:0] tags_a, tags_b;
    assign ctl_a  = {pc_a, ifid_a, bub_a, fl_a};
    assign ctl_b  = {pc_b, ifid_b, bub_b, fl_b};
    assign tags_a = {idexrd_a, idexmr_a, exmemrd_a, exmemrw_a, memwbrd_a, memwbrw_a};
    assign tags_b = {idexrd_b, idexmr_b, exmemrd_b, exmemrw_b, memwbrd_b, memwbrw_b};

    // Reference model: instruction records in flight, bubbles still owed, bubble tally.
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } mtag_t;

    mtag_t pipe [2][3];
    int    owed [2];
    int    tally[2];
    int    depth[2] = '{1, 3};

`ifdef HAZARD_STALL_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) pipe[i][s] = '0;
            owed[i]  = 0;
            tally[i] = 0;
        end
    endtask

    // One clock cycle: drive decode inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic [4:0] a1, input logic [4:0] a2,
                        input logic ua1, input logic ua2,
                        input logic [4:0] d, input logic w, input logic m,
                        input logic b, input logic h);
        logic [3:0]  e_ctl;
        logic        hazard;
        logic [17:0] e_tags;
        rs1 = a1; rs2 = a2; u1 = ua1; u2 = ua2;
        id_rd = d; id_rw = w; id_mr = m; br = b; hold = h;
        #1;
        for (int i = 0; i < 2; i++) begin
            hazard = pipe[i][0].mr && (pipe[i][0].rd != 0) &&
                     ((pipe[i][0].rd == a1 && ua1) || (pipe[i][0].rd == a2 && ua2));
            if (h)                         e_ctl = 4'b0000;
            else if (b)                    e_ctl = 4'b1101;
            else if (owed[i] > 0 || hazard) e_ctl = 4'b0010;
            else                           e_ctl = 4'b1100;
            e_tags = {pipe[i][0].rd, pipe[i][0].mr, pipe[i][1].rd, pipe[i][1].rw,
                      pipe[i][2].rd, pipe[i][2].rw};
            check(i == 0 ? "ctl_n1" : "ctl_n3", {28'd0, (i == 0) ? ctl_a : ctl_b}, {28'd0, e_ctl});
            check(i == 0 ? "tags_n1" : "tags_n3", {14'd0, (i == 0) ? tags_a : tags_b}, {14'd0, e_tags});
            check(i == 0 ? "cnt_n1" : "cnt_n3", {16'd0, (i == 0) ? sc_a : sc_b}, tally[i]);
            if (!h) begin
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = (e_ctl[1] || e_ctl[0]) ? mtag_t'(0) : mtag_t'({d, w, m});
                if (CNT_ON && e_ctl[1] && tally[i] < 65535) tally[i]++;
                if (b)                owed[i] = 0;
                else if (owed[i] > 0) owed[i]--;
                else if (hazard)      owed[i] = depth[i] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; id_rd = '0; id_rw = 0; id_mr = 0; br = 0; hold = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_tags", {14'd0, tags_b}, 32'd0);
        check("reset_ctl", {28'd0, ctl_b}, 32'hC);
        check("reset_state", {30'd0, u_b.state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // lw x5 ; add x6,x5,x7 held in decode while stalled
        step(0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        check("n1_idex_rd_after_bubble", {27'd0, idexrd_a}, 32'd0);
        check("n1_exmem_rd_after_bubble", {27'd0, exmemrd_a}, 32'd5);
        for (int k = 0; k < 3; k++) step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        check("n3_stall_count", {16'd0, sc_b}, CNT_ON ? 32'd3 : 32'd0);
        check("n1_stall_count", {16'd0, sc_a}, CNT_ON ? 32'd1 : 32'd0);
        nop(3);

        // load-use and taken branch together: flush wins
        step(0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(5, 0, 1, 0, 6, 1, 0, 1, 0);
        check("flush_state", {30'd0, u_b.state}, 32'd2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("run_after_flush", {30'd0, u_b.state}, 32'd0);
        nop(2);

        // Hold for four cycles in the middle of a 3-bubble stall
        step(0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(5, 7, 1, 1, 6, 1, 0, 0, 1);
        check("held_counter", {30'd0, u_b.cnt}, 32'd2);
        for (int k = 0; k < 3; k++) step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        nop(3);

        // lw x0 ; add x1,x0,x0 never stalls
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0, 0, 0);
        nop(3);

        // randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 400; k++) begin
            logic [4:0] regs [4];
            regs[0] = 5'd0; regs[1] = 5'd5; regs[2] = 5'd6; regs[3] = 5'd7;
            step(regs[$urandom_range(3)], regs[$urandom_range(3)],
                 1'($urandom), 1'($urandom),
                 regs[$urandom_range(3)], 1'($urandom), 1'($urandom),
                 ($urandom_range(9) == 0), ($urandom_range(6) == 0));
        end
        nop(3);

        // reset asserted in the middle of a stall
        step(0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        rs1 = 5; rs2 = 7; u1 = 1; u2 = 1; id_rd = 6; id_rw = 1; id_mr = 0; br = 0; hold = 0;
        reset = 1'b1;
        #1;
        check("async_reset_tags", {14'd0, tags_b}, 32'd0);
        check("async_reset_pc", {31'd0, pc_b}, 32'd1);
        check("async_reset_cnt", {16'd0, sc_b}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(5, 7, 1, 1, 6, 1, 0, 0, 0);
        nop(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
